// File: rtl/as_pack.sv
// ---------------------------------------------------------------------------
// as_pack
// Shared definitions for the GPIO peripheral: default pin count, width of
// the byte offset inside the GPIO window and the register selector
// encoding taken from offs_i[4:3].
// ---------------------------------------------------------------------------
package as_pack;

    localparam int nr_gpios        = 32;
    localparam int gpio_addr_width = 5;
    localparam int GPIO_OFFS_W     = gpio_addr_width;

    // Register selected by offs_i[4:3]; every access is a full dword.
    typedef enum logic [1:0] {
        GPIO_DOUT = 2'd0,
        GPIO_DIR  = 2'd1,
        GPIO_DIN  = 2'd2,
        GPIO_EDGE = 2'd3
    } gpio_reg_e;

endpackage

// File: rtl/as_gpio_sync.sv
// ---------------------------------------------------------------------------
// as_gpio_sync
// Multi-stage synchroniser for a bus of asynchronous pad inputs, followed
// by one extra flop per bit for rising-edge detection.
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous reset, active high
//   async_i  raw pad values (WIDTH bits)
//   sync_o   synchronised values (last synchroniser stage)
//   rise_o   one-cycle rising-edge pulse per bit
// STAGES must be at least 2.
// ---------------------------------------------------------------------------
module as_gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]             prev_q, prev_d;

    // Shift the pad values down the synchroniser chain; the edge flop keeps
    // the previous synchronised value.
    always_comb begin
        sync_d    = '0;
        sync_d[0] = async_i;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser and edge-detect registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/as_gpio_port.sv
// ---------------------------------------------------------------------------
// as_gpio_port
// Memory-mapped GPIO peripheral on the data bus. Holds the output data
// (DOUT), direction (DIR, 1 = output) and sticky rising-edge (EDGE, write
// 1 to clear) registers, exposes the synchronised pins (DIN) and drives the
// tri-state pad bus. cs_o pulses the cycle after every accepted DOUT write.
// Ports:
//   clk_i, rst_i  clock / asynchronous active-high reset
//   sel_i         address decode hit; qualifies we_i and re_i
//   we_i, re_i    store / load request
//   offs_i        byte offset in the window; [4:3] selects the register
//   be_i          store byte enables
//   wdata_i       store data
//   rdata_o       load data, valid with rvalid_o one cycle after request
//   rvalid_o      load data valid
//   gpio_io       pad bus
//   cs_o          DOUT write strobe
// ---------------------------------------------------------------------------
module as_gpio_port
    import as_pack::*;
#(
    parameter int NR_GPIOS = nr_gpios,
    parameter int DATA_W   = 64,
    parameter int OFFS_W   = GPIO_OFFS_W,
    parameter int SYNC_STG = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sel_i,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [OFFS_W-1:0]   offs_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o,
    inout  wire  [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o
);

    logic                wr_en;
    logic                rd_en;
    gpio_reg_e           reg_sel;
    logic [NR_GPIOS-1:0] wr_mask;
    logic [NR_GPIOS-1:0] wr_bits;
    logic [NR_GPIOS-1:0] pin_sync;
    logic [NR_GPIOS-1:0] pin_rise;
    logic [NR_GPIOS-1:0] rd_bits;

    logic [NR_GPIOS-1:0] dout_q, dout_d;
    logic [NR_GPIOS-1:0] dir_q, dir_d;
    logic [NR_GPIOS-1:0] edge_q, edge_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                cs_q, cs_d;

    // Low offset bits, bytes above the pin range and data bits above the
    // pin range carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{offs_i, be_i, wdata_i};

    assign wr_en   = sel_i & we_i;
    assign rd_en   = sel_i & re_i;
    assign reg_sel = gpio_reg_e'(offs_i[4:3]);

    // Per-pin byte-enable mask and pad drivers.
    for (genvar g = 0; g < NR_GPIOS; g++) begin : g_pin
        assign wr_mask[g] = be_i[g/8];
        assign gpio_io[g] = dir_q[g] ? dout_q[g] : 1'bz;
    end

    assign wr_bits = wdata_i[NR_GPIOS-1:0] & wr_mask;

    as_gpio_sync #(
        .WIDTH  (NR_GPIOS),
        .STAGES (SYNC_STG)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (gpio_io),
        .sync_o  (pin_sync),
        .rise_o  (pin_rise)
    );

    // Register write path. Only enabled bytes change; DIN is read-only.
    // The edge set is OR-ed in after the W1C clear so that a new edge
    // arriving in the same cycle as a clear is not lost.
    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        edge_d = edge_q;
        cs_d   = 1'b0;
        if (wr_en) begin
            unique case (reg_sel)
                GPIO_DOUT: begin
                    dout_d = (dout_q & ~wr_mask) | wr_bits;
                    cs_d   = 1'b1;
                end
                GPIO_DIR:  dir_d  = (dir_q & ~wr_mask) | wr_bits;
                GPIO_EDGE: edge_d = edge_q & ~wr_bits;
                default:   ;
            endcase
        end
        edge_d = edge_d | pin_rise;
    end

    // Read path: data is selected from the current (pre-write) register
    // values and registered, giving one cycle of latency.
    always_comb begin
        rd_bits = '0;
        unique case (reg_sel)
            GPIO_DOUT: rd_bits = dout_q;
            GPIO_DIR:  rd_bits = dir_q;
            GPIO_DIN:  rd_bits = pin_sync;
            GPIO_EDGE: rd_bits = edge_q;
            default:   rd_bits = '0;
        endcase
        rdata_d  = '0;
        rvalid_d = rd_en;
        if (rd_en) begin
            rdata_d[NR_GPIOS-1:0] = rd_bits;
        end
    end

    // Architectural registers and bus outputs; reset drops any pending
    // read response or strobe and releases the pads at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_q   <= '0;
            dir_q    <= '0;
            edge_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            cs_q     <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            dir_q    <= dir_d;
            edge_q   <= edge_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            cs_q     <= cs_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign cs_o     = cs_q;

endmodule
